aes_cipher_host_adapter: RTL and testbench

//   Host-side driver for aes_cipher_top: accepts plaintext blocks over a valid/ready stream,

---
 rtl/aes_adapter_pkg.sv | 21 ++
 rtl/aes_timeout_ctr.sv | 38 +++
 rtl/aes_cipher_host_adapter.sv | 145 ++++++++++++++
 tb/tb_aes_cipher_host_adapter.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_adapter_pkg
// Description : Shared types and constants for the AES cipher host adapter.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_adapter_pkg;

    // AES block, key and ciphertext width
    localparam int AES_BLK_W = 128;

    // Adapter control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/aes_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : aes_timeout_ctr
// Description : WAIT-state cycle counter. Cleared by i_clr, advanced by i_en;
//               o_tc flags the cycle on which the TIMEOUT_CYC-th enabled
//               cycle completes.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_timeout_ctr #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count enabled cycles; clear has priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = i_en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/aes_cipher_host_adapter.sv
`default_nettype none
// ============================================================================
// Module      : aes_cipher_host_adapter
// Description : Stream-side driver for aes_cipher_top. Accepts one plaintext
//               block, pulses ld with key/text_in, waits for done, and holds
//               the ciphertext on a valid/ready result stream.
//               Optional feature macro: AES_TIMEOUT_EN (WAIT-state abort).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_cipher_host_adapter
    import aes_adapter_pkg::*;
#(
    parameter int DATA_W      = AES_BLK_W,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] key_i,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              aes_ld,
    output logic [DATA_W-1:0] aes_key,
    output logic [DATA_W-1:0] aes_text_in,
    input  logic              aes_done,
    input  logic [DATA_W-1:0] aes_text_out,
    output logic              busy,
    output logic              err_timeout
);

    // A counter too narrow to reach the limit would never abort
    generate
        if (2**CNT_W <= TIMEOUT_CYC) begin : g_cnt_w_check
            $error("CNT_W too narrow for TIMEOUT_CYC");
        end
    endgenerate

    state_t              r_state;
    logic                r_s_ready;
    logic                r_m_valid;
    logic                r_aes_ld;
    logic                r_busy;
    logic [DATA_W-1:0]   r_m_data;
    logic [DATA_W-1:0]   r_aes_key;
    logic [DATA_W-1:0]   r_aes_text_in;
    logic                w_accept;
    logic                w_tc;

    assign w_accept = s_valid && r_s_ready;

`ifdef AES_TIMEOUT_EN
    logic r_err_timeout;

    aes_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (r_state == LOAD),
        .i_en  (r_state == WAIT),
        .o_tc  (w_tc)
    );

    assign err_timeout = r_err_timeout;
`else
    assign w_tc        = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Block-sequencing FSM; every output is registered here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_s_ready     <= 1'b1;
            r_m_valid     <= 1'b0;
            r_aes_ld      <= 1'b0;
            r_busy        <= 1'b0;
            r_m_data      <= '0;
            r_aes_key     <= '0;
            r_aes_text_in <= '0;
`ifdef AES_TIMEOUT_EN
            r_err_timeout <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_aes_text_in <= s_data;
                        r_aes_key     <= key_i;
                        r_aes_ld      <= 1'b1;
                        r_s_ready     <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= LOAD;
                    end
                end
                LOAD: begin
                    // done in this cycle belongs to no block of ours
                    r_aes_ld <= 1'b0;
                    r_state  <= WAIT;
                end
                WAIT: begin
                    // done on the terminal-count cycle still completes normally
                    if (aes_done) begin
                        r_m_data  <= aes_text_out;
                        r_m_valid <= 1'b1;
                        r_state   <= HOLD;
                    end else if (w_tc) begin
`ifdef AES_TIMEOUT_EN
                        r_err_timeout <= 1'b1;
`endif
                        r_busy    <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_ready     = r_s_ready;
    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign aes_ld      = r_aes_ld;
    assign aes_key     = r_aes_key;
    assign aes_text_in = r_aes_text_in;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_aes_cipher_host_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_cipher_host_adapter
// Description : Self-checking bench for aes_cipher_host_adapter with a
//               behavioural AES-128 core and a queue-based reference model.
//               Timeout scenario is built only with AES_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_cipher_host_adapter;

    localparam int c_W  = 128;
    localparam int c_TO = 64;

    localparam logic [c_W-1:0] c_FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [c_W-1:0] c_FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [c_W-1:0] c_FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [c_W-1:0] key_i = '0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [c_W-1:0] s_data = '0;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [c_W-1:0] m_data;
    logic           aes_ld;
    logic [c_W-1:0] aes_key;
    logic [c_W-1:0] aes_text_in;
    logic           aes_done = 1'b0;
    logic [c_W-1:0] aes_text_out = '0;
    logic           busy;
    logic           err_timeout;

    aes_cipher_host_adapter #(
        .DATA_W      (c_W),
        .TIMEOUT_CYC (c_TO),
        .CNT_W       (7)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .key_i        (key_i),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .aes_ld       (aes_ld),
        .aes_key      (aes_key),
        .aes_text_in  (aes_text_in),
        .aes_done     (aes_done),
        .aes_text_out (aes_text_out),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    initial forever #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [c_W-1:0] obs, input logic [c_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural AES-128 (FIPS-197)
    // ------------------------------------------------------------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [c_W-1:0] aes128(input logic [c_W-1:0] k, input logic [c_W-1:0] p);
        logic [7:0]     s [16];
        logic [7:0]     w [16];
        logic [7:0]     t [16];
        logic [7:0]     tmp [4];
        logic [7:0]     a0, a1, a2, a3, rc;
        logic [c_W-1:0] r;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            w[i] = k[127-8*i -: 8];
            s[i] = p[127-8*i -: 8] ^ w[i];
        end
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c+row] = sbox[s[4*((c+row)%4)+row]];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            tmp[0] = sbox[w[13]] ^ rc;
            tmp[1] = sbox[w[14]];
            tmp[2] = sbox[w[15]];
            tmp[3] = sbox[w[12]];
            for (int j = 0; j < 4; j++)  w[j] ^= tmp[j];
            for (int i = 4; i < 16; i++) w[i] ^= w[i-4];
            rc = xt(rc);
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[i];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    function automatic logic [c_W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ------------------------------------------------------------------
    // Cipher core model: ld -> done after core_lat cycles (posedge + 2)
    // ------------------------------------------------------------------
    int             core_lat  = 11;
    logic           core_mute = 1'b0;
    logic           stray_req = 1'b0;
    logic           real_done = 1'b0;
    int             pend      = 0;
    logic [c_W-1:0] core_res  = '0;

    initial forever begin
        @(posedge clk);
        #2;
        aes_done  = 1'b0;
        real_done = 1'b0;
        if (!rst) begin
            pend = 0;
        end else if (stray_req) begin
            stray_req    = 1'b0;
            aes_done     = 1'b1;
            aes_text_out = rand128();
        end else if (aes_ld) begin
            core_res = aes128(aes_key, aes_text_in);
            pend     = core_lat;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0 && !core_mute) begin
                aes_done     = 1'b1;
                aes_text_out = core_res;
                real_done    = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Random sink back-pressure
    // ------------------------------------------------------------------
    logic rand_mr = 1'b0;

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_mr) m_ready = 1'($urandom_range(0, 1));
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard, sampled on the falling edge
    // ------------------------------------------------------------------
    logic [c_W-1:0] exp_q [$];
    logic           prev_accept = 1'b0;
    logic           prev_ld     = 1'b0;
    logic           prev_rdone  = 1'b0;
    logic           prev_stall  = 1'b0;
    logic [c_W-1:0] prev_mdata  = '0;
    logic [c_W-1:0] acc_key     = '0;
    logic [c_W-1:0] acc_text    = '0;
    int             ld_cnt      = 0;
    int             out_cnt     = 0;
    logic           mv_seen     = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            exp_q.delete();
            prev_accept = 1'b0;
            prev_ld     = 1'b0;
            prev_rdone  = 1'b0;
            prev_stall  = 1'b0;
        end else begin
            if (prev_accept) begin
                check("ld_after_accept", aes_ld, 1);
                check("aes_key", aes_key, acc_key);
                check("aes_text_in", aes_text_in, acc_text);
            end
            if (aes_ld) begin
                ld_cnt++;
                check("ld_width", prev_ld, 0);
            end
            if (prev_rdone) check("done_to_valid", m_valid, 1);
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_mdata);
            end
            if (m_valid) mv_seen = 1'b1;
            if (m_valid && m_ready) begin
                check("out_has_exp", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("out_data", m_data, exp_q.pop_front());
                out_cnt++;
            end
            prev_accept = s_valid && s_ready;
            if (prev_accept) begin
                exp_q.push_back(aes128(key_i, s_data));
                acc_key  = key_i;
                acc_text = s_data;
            end
            prev_ld    = aes_ld;
            prev_rdone = real_done;
            prev_stall = m_valid && !m_ready;
            prev_mdata = m_data;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [c_W-1:0] k, input logic [c_W-1:0] d);
        logic acc;
        acc     = 1'b0;
        s_valid = 1'b1;
        key_i   = k;
        s_data  = d;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (s_ready) acc = 1'b1;
        end
        check("accept", acc, 1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 200 && !m_valid; i++) @(negedge clk);
        check("m_valid_wait", m_valid, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 1);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_aes_ld"}, aes_ld, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err_timeout, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_aes_key"}, aes_key, 0);
        check({tag, "_text_in"}, aes_text_in, 0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    int             l0;
    int             base;
    int             cnt;
    logic [c_W-1:0] md;
    logic [c_W-1:0] k2, d2;

    initial begin
        build_sbox();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        tick();
        rst = 1'b1;
        tick();

        // FIPS-197 C.1 vector
        m_ready  = 1'b1;
        core_lat = 11;
        l0       = ld_cnt;
        send(c_FIPS_KEY, c_FIPS_PT);
        wait_valid();
        check("fips_ct", m_data, c_FIPS_CT);
        tick();
        check("fips_ld_count", 32'(ld_cnt - l0), 1);

        // Sink stall: 20 cycles, second block must wait
        m_ready  = 1'b0;
        core_lat = 4;
        send(rand128(), rand128());
        wait_valid();
        tick();
        k2      = rand128();
        d2      = rand128();
        s_valid = 1'b1;
        key_i   = k2;
        s_data  = d2;
        l0      = ld_cnt;
        md      = m_data;
        repeat (20) begin
            @(negedge clk);
            check("stall_s_ready", s_ready, 0);
            check("stall_m_data", m_data, md);
        end
        check("stall_no_ld", 32'(ld_cnt - l0), 0);
        tick();
        m_ready = 1'b1;
        send(k2, d2);
        wait_valid();
        tick();

        // Stray done in IDLE
        tick();
        md        = m_data;
        stray_req = 1'b1;
        repeat (3) @(negedge clk);
        check("stray_idle_busy", busy, 0);
        check("stray_idle_s_ready", s_ready, 1);
        check("stray_idle_m_valid", m_valid, 0);
        check("stray_idle_m_data", m_data, md);

        // Stray done in HOLD
        tick();
        m_ready = 1'b0;
        send(rand128(), rand128());
        wait_valid();
        tick();
        md        = m_data;
        stray_req = 1'b1;
        repeat (3) @(negedge clk);
        check("stray_hold_m_data", m_data, md);
        check("stray_hold_m_valid", m_valid, 1);
        check("stray_hold_busy", busy, 1);
        tick();
        m_ready = 1'b1;
        tick();
        tick();

        // Back-to-back random blocks with random sink readiness
        base    = out_cnt;
        rand_mr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            core_lat = $urandom_range(1, 15);
            send(rand128(), rand128());
        end
        for (int i = 0; i < 2000 && out_cnt < base + 8; i++) @(negedge clk);
        check("rand_out_count", 32'(out_cnt - base), 8);
        tick();
        rand_mr = 1'b0;
        m_ready = 1'b1;
        tick();

        // Reset asserted while waiting for done
        core_lat = 12;
        send(rand128(), rand128());
        repeat (4) tick();
        check("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        repeat (2) tick();
        rst = 1'b1;
        tick();
        core_lat = 7;
        send(c_FIPS_KEY, c_FIPS_PT);
        wait_valid();
        check("fips_after_rst", m_data, c_FIPS_CT);
        tick();
        tick();

`ifdef AES_TIMEOUT_EN
        // Silent core: adapter must abort after c_TO WAIT cycles
        core_mute = 1'b1;
        core_lat  = 5;
        mv_seen   = 1'b0;
        send(rand128(), rand128());
        cnt = 0;
        for (int i = 0; i < 300 && busy; i++) begin
            @(negedge clk);
            if (busy && !aes_ld) cnt++;
        end
        tick();
        check("timeout_cycles", 32'(cnt), 32'(c_TO));
        check("timeout_err", err_timeout, 1);
        check("timeout_busy", busy, 0);
        check("timeout_no_valid", mv_seen, 0);
        exp_q.delete();
        core_mute = 1'b0;
        send(c_FIPS_KEY, c_FIPS_PT);
        wait_valid();
        check("post_timeout_ct", m_data, c_FIPS_CT);
        check("err_sticky", err_timeout, 1);
        tick();
        tick();
`else
        check("err_tied0", err_timeout, 0);
`endif

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
